// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the three-requester memory arbiter.
// Holds the FSM encoding, requester indices and bus widths.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NUM_REQ = 3;

    localparam logic [1:0] REQ_CPU = 2'd0;
    localparam logic [1:0] REQ_CNT = 2'd1;
    localparam logic [1:0] REQ_IO  = 2'd2;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StIssue    = 2'd1,
        StComplete = 2'd2
    } arb_state_e;

    // Requester index that follows idx, wrapping REQ_IO back to REQ_CPU.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == REQ_IO) ? REQ_CPU : idx + 2'd1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: scans requesters starting at ptr_i and wrapping.
// A constant ptr_i of REQ_CPU degenerates to fixed priority 0 > 1 > 2.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [1:0]         winner_o,
    output logic               valid_o
);

    logic [1:0] first_idx;
    logic [1:0] second_idx;
    logic [1:0] third_idx;

    // Encoding 3 is not a requester; treat it as a search from requester 0.
    assign first_idx  = (ptr_i > REQ_IO) ? REQ_CPU : ptr_i;
    assign second_idx = next_idx(first_idx);
    assign third_idx  = next_idx(second_idx);

    always_comb begin
        valid_o  = |req_i;
        winner_o = first_idx;
        if (req_i[first_idx]) begin
            winner_o = first_idx;
        end else if (req_i[second_idx]) begin
            winner_o = second_idx;
        end else if (req_i[third_idx]) begin
            winner_o = third_idx;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester single-port memory arbiter: IDLE -> ISSUE -> COMPLETE, one access per 3 cycles.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [ADDR_W-1:0]    addr0_i,
    input  logic [ADDR_W-1:0]    addr1_i,
    input  logic [ADDR_W-1:0]    addr2_i,
    input  logic [DATA_W-1:0]    wdata0_i,
    input  logic [DATA_W-1:0]    wdata1_i,
    input  logic [DATA_W-1:0]    wdata2_i,
    input  logic [NUM_REQ-1:0]   we_i,
    output logic [NUM_REQ-1:0]   ack_o,
    output logic [DATA_W-1:0]    rdata_o,
    output logic                 busy_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [DATA_W-1:0]    mem_wdata_o,
    output logic                 mem_wr_o,
    input  logic [DATA_W-1:0]    mem_rdata_i
);

    arb_state_e          state_q, state_d;
    logic [1:0]          win_q, win_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [1:0]          pick_ptr;
    logic [1:0]          pick_winner;
    logic                pick_valid;

    mem_arb_pick u_pick (
        .req_i    (req_i),
        .ptr_i    (pick_ptr),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

`ifdef MEM_ARB_RR_EN
    // ptr_q holds the index where the next search starts (one past the last winner).
    logic [1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StIdle && pick_valid) begin
            ptr_d = next_idx(pick_winner);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= REQ_CPU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = REQ_CPU;
`endif

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        ack_o       = '0;
        rdata_o     = rdata_q;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wr_o    = 1'b0;
        busy_o      = (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    win_d   = pick_winner;
                    we_d    = we_i[pick_winner];
                    state_d = StIssue;
                    case (pick_winner)
                        REQ_CNT: begin
                            addr_d  = addr1_i;
                            wdata_d = wdata1_i;
                        end
                        REQ_IO: begin
                            addr_d  = addr2_i;
                            wdata_d = wdata2_i;
                        end
                        default: begin
                            addr_d  = addr0_i;
                            wdata_d = wdata0_i;
                        end
                    endcase
                end
            end
            StIssue: begin
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                mem_wr_o    = we_q;
                state_d     = StComplete;
            end
            StComplete: begin
                ack_o = 3'b001 << win_q;
                // Read data arrives this cycle; pass it through and keep it for later.
                if (!we_q) begin
                    rdata_o = mem_rdata_i;
                    rdata_d = mem_rdata_i;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            win_q   <= REQ_CPU;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a registered-read memory model and an ack scoreboard.
// Expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [2:0]  ack;
    logic [11:0] addr0, addr1, addr2, mem_addr;
    logic [15:0] wdata0, wdata1, wdata2, rdata, mem_wdata, mem_rdata;
    logic        busy;
    logic        mem_wr;

    logic        pre_we;
    logic [11:0] pre_addr;
    logic [15:0] pre_data;
    logic [15:0] mem [0:4095];

    typedef struct packed {
        logic [2:0]  ack;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks;
    int   n_errors;

    mem_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .addr0_i     (addr0),
        .addr1_i     (addr1),
        .addr2_i     (addr2),
        .wdata0_i    (wdata0),
        .wdata1_i    (wdata1),
        .wdata2_i    (wdata2),
        .we_i        (we),
        .ack_o       (ack),
        .rdata_o     (rdata),
        .busy_o      (busy),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wr_o    (mem_wr),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ack !== 3'b000) begin n_errors++; $display("FAIL reset_ack: got %b want 000", ack); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (mem_wr !== 1'b0) begin n_errors++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        n_checks++; if (rdata !== 16'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
        n_checks++; if (mem_addr !== 12'h0) begin n_errors++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
        n_checks++; if (mem_wdata !== 16'h0) begin n_errors++; $display("FAIL reset_mem_wdata: got %h want 0000", mem_wdata); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_idle_quiet();
        int bad;
        bad = 0;
        req = 3'b000;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0 || ack !== 3'b000 || mem_wr !== 1'b0 || mem_addr !== 12'h0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        bit done;
        bit wr_seen;
        done    = 1'b0;
        wr_seen = 1'b0;
        req   = 3'b001;
        we    = 3'b000;
        addr0 = 12'h123;
        sb_q.push_back('{ack: 3'b001, rdata: 16'h4A5B});
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            if (mem_wr) wr_seen = 1'b1;
            if (c == 1) begin
                n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL read_busy_idle: got %b want 0", busy); end
            end
            if (c == 2) begin
                n_checks++; if (mem_addr !== 12'h123) begin n_errors++; $display("FAIL read_mem_addr: got %h want 123", mem_addr); end
                n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL read_busy_issue: got %b want 1", busy); end
            end
            if (ack !== 3'b000) begin
                done = 1'b1;
                n_checks++; if (c !== 3) begin n_errors++; $display("FAIL read_latency: got %0d want 3", c); end
                if (sb_q.size() == 0) begin
                    n_checks++; n_errors++; $display("FAIL read_unexpected_ack: got %b want none", ack);
                end else begin
                    e = sb_q.pop_front();
                    n_checks++; if (ack !== e.ack) begin n_errors++; $display("FAIL read_ack: got %b want %b", ack, e.ack); end
                    n_checks++; if (rdata !== e.rdata) begin n_errors++; $display("FAIL read_rdata: got %h want %h", rdata, e.rdata); end
                end
            end
        end
        if (!done) begin n_checks++; n_errors++; $display("FAIL read_timeout: got no ack want ack"); end
        n_checks++; if (wr_seen !== 1'b0) begin n_errors++; $display("FAIL read_mem_wr: got 1 want 0"); end
        @(posedge clk);
        #1;
        req = 3'b000;
    endtask

    task automatic test_single_write();
        bit done;
        int wr_cnt;
        done   = 1'b0;
        wr_cnt = 0;
        req    = 3'b100;
        we     = 3'b100;
        addr2  = 12'h7FF;
        wdata2 = 16'hBEEF;
        // A write ack leaves rdata at the value from the previous read.
        sb_q.push_back('{ack: 3'b100, rdata: 16'h4A5B});
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            if (mem_wr) begin
                wr_cnt++;
                n_checks++; if (mem_addr !== 12'h7FF) begin n_errors++; $display("FAIL write_mem_addr: got %h want 7ff", mem_addr); end
                n_checks++; if (mem_wdata !== 16'hBEEF) begin n_errors++; $display("FAIL write_mem_wdata: got %h want beef", mem_wdata); end
            end
            if (ack !== 3'b000) begin
                done = 1'b1;
                if (sb_q.size() == 0) begin
                    n_checks++; n_errors++; $display("FAIL write_unexpected_ack: got %b want none", ack);
                end else begin
                    e = sb_q.pop_front();
                    n_checks++; if (ack !== e.ack) begin n_errors++; $display("FAIL write_ack: got %b want %b", ack, e.ack); end
                    n_checks++; if (rdata !== e.rdata) begin n_errors++; $display("FAIL write_rdata_hold: got %h want %h", rdata, e.rdata); end
                end
            end
        end
        if (!done) begin n_checks++; n_errors++; $display("FAIL write_timeout: got no ack want ack"); end
        // Back-to-back read of the same word from requester 0.
        @(posedge clk);
        #1;
        req   = 3'b001;
        we    = 3'b000;
        addr0 = 12'h7FF;
        sb_q.push_back('{ack: 3'b001, rdata: 16'hBEEF});
        done = 1'b0;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            if (mem_wr) wr_cnt++;
            if (ack !== 3'b000) begin
                done = 1'b1;
                if (sb_q.size() == 0) begin
                    n_checks++; n_errors++; $display("FAIL readback_unexpected_ack: got %b want none", ack);
                end else begin
                    e = sb_q.pop_front();
                    n_checks++; if (ack !== e.ack) begin n_errors++; $display("FAIL readback_ack: got %b want %b", ack, e.ack); end
                    n_checks++; if (rdata !== e.rdata) begin n_errors++; $display("FAIL readback_rdata: got %h want %h", rdata, e.rdata); end
                end
            end
        end
        if (!done) begin n_checks++; n_errors++; $display("FAIL readback_timeout: got no ack want ack"); end
        n_checks++; if (wr_cnt !== 1) begin n_errors++; $display("FAIL write_pulse_count: got %0d want 1", wr_cnt); end
        @(posedge clk);
        #1;
        req = 3'b000;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  exp_ack [4];
        logic [15:0] exp_dat;
        int got;
        int last_c;
        got    = 0;
        last_c = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_ack[0] = 3'b001; exp_ack[1] = 3'b010; exp_ack[2] = 3'b100; exp_ack[3] = 3'b001;
`else
        exp_ack[0] = 3'b001; exp_ack[1] = 3'b001; exp_ack[2] = 3'b001; exp_ack[3] = 3'b001;
`endif
        for (int i = 0; i < 4; i++) begin
            case (exp_ack[i])
                3'b010:  exp_dat = 16'hA001;
                3'b100:  exp_dat = 16'hA002;
                default: exp_dat = 16'hA000;
            endcase
            sb_q.push_back('{ack: exp_ack[i], rdata: exp_dat});
        end
        req   = 3'b111;
        we    = 3'b000;
        addr0 = 12'h300;
        addr1 = 12'h301;
        addr2 = 12'h302;
        for (int c = 1; c <= 20 && got < 4; c++) begin
            @(negedge clk);
            if (ack !== 3'b000) begin
                n_checks++;
                if ((got == 0 && c !== 3) || (got != 0 && c - last_c !== 3)) begin
                    n_errors++; $display("FAIL b2b_spacing: got cycle %0d after %0d want 3 apart", c, last_c);
                end
                last_c = c;
                got++;
                if (sb_q.size() == 0) begin
                    n_checks++; n_errors++; $display("FAIL b2b_unexpected_ack: got %b want none", ack);
                end else begin
                    e = sb_q.pop_front();
                    n_checks++; if (ack !== e.ack) begin n_errors++; $display("FAIL b2b_ack_%0d: got %b want %b", got, ack, e.ack); end
                    n_checks++; if (rdata !== e.rdata) begin n_errors++; $display("FAIL b2b_rdata_%0d: got %h want %h", got, rdata, e.rdata); end
                end
            end
        end
        if (got != 4) begin n_checks++; n_errors++; $display("FAIL b2b_timeout: got %0d acks want 4", got); end
        @(posedge clk);
        #1;
        req = 3'b000;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_issue();
        bit done;
        int late_ack;
        done     = 1'b0;
        late_ack = 0;
        req    = 3'b001;
        we     = 3'b001;
        addr0  = 12'h010;
        wdata0 = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (mem_wr !== 1'b1) begin n_errors++; $display("FAIL rst_issue_wr_before: got %b want 1", mem_wr); end
        n_checks++; if (mem_addr !== 12'h010) begin n_errors++; $display("FAIL rst_issue_addr: got %h want 010", mem_addr); end
        rst = 1'b1;
        req = 3'b000;
        we  = 3'b000;
        @(posedge clk);
        #1;
        n_checks++; if (mem_wr !== 1'b0) begin n_errors++; $display("FAIL rst_issue_mem_wr: got %b want 0", mem_wr); end
        n_checks++; if (ack !== 3'b000) begin n_errors++; $display("FAIL rst_issue_ack: got %b want 000", ack); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_issue_busy: got %b want 0", busy); end
        n_checks++; if (rdata !== 16'h0) begin n_errors++; $display("FAIL rst_issue_rdata: got %h want 0000", rdata); end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack !== 3'b000 || mem_wr !== 1'b0) late_ack++;
        end
        n_checks++; if (late_ack !== 0) begin n_errors++; $display("FAIL rst_issue_no_ack: got %0d active cycles want 0", late_ack); end
        @(posedge clk);
        #1;
        req   = 3'b010;
        addr1 = 12'h200;
        sb_q.push_back('{ack: 3'b010, rdata: 16'h3C3C});
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            if (ack !== 3'b000) begin
                done = 1'b1;
                n_checks++; if (c !== 3) begin n_errors++; $display("FAIL post_rst_latency: got %0d want 3", c); end
                if (sb_q.size() == 0) begin
                    n_checks++; n_errors++; $display("FAIL post_rst_unexpected_ack: got %b want none", ack);
                end else begin
                    e = sb_q.pop_front();
                    n_checks++; if (ack !== e.ack) begin n_errors++; $display("FAIL post_rst_ack: got %b want %b", ack, e.ack); end
                    n_checks++; if (rdata !== e.rdata) begin n_errors++; $display("FAIL post_rst_rdata: got %h want %h", rdata, e.rdata); end
                end
            end
        end
        if (!done) begin n_checks++; n_errors++; $display("FAIL post_rst_timeout: got no ack want ack"); end
        @(posedge clk);
        #1;
        req = 3'b000;
    endtask

    task automatic test_input_churn();
        int extra;
        extra  = 0;
        req    = 3'b010;
        we     = 3'b000;
        addr1  = 12'h050;
        wdata1 = 16'h0000;
        sb_q.push_back('{ack: 3'b010, rdata: 16'h1111});
        @(negedge clk);
        @(posedge clk);
        #1;
        // Everything changes while the access is in flight, including dropping req.
        req    = 3'b000;
        addr1  = 12'h060;
        wdata1 = 16'hFFFF;
        we     = 3'b010;
        @(negedge clk);
        n_checks++; if (mem_addr !== 12'h050) begin n_errors++; $display("FAIL churn_mem_addr: got %h want 050", mem_addr); end
        n_checks++; if (mem_wr !== 1'b0) begin n_errors++; $display("FAIL churn_mem_wr: got %b want 0", mem_wr); end
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++; n_errors++; $display("FAIL churn_scoreboard_empty: got empty want entry");
        end else begin
            e = sb_q.pop_front();
            n_checks++; if (ack !== e.ack) begin n_errors++; $display("FAIL churn_ack: got %b want %b", ack, e.ack); end
            n_checks++; if (rdata !== e.rdata) begin n_errors++; $display("FAIL churn_rdata: got %h want %h", rdata, e.rdata); end
        end
        repeat (4) begin
            @(negedge clk);
            if (ack !== 3'b000 || busy !== 1'b0) extra++;
        end
        n_checks++; if (extra !== 0) begin n_errors++; $display("FAIL churn_no_second_access: got %0d active cycles want 0", extra); end
        @(posedge clk);
        #1;
        we = 3'b000;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        req      = 3'b000;
        we       = 3'b000;
        addr0    = '0;
        addr1    = '0;
        addr2    = '0;
        wdata0   = '0;
        wdata1   = '0;
        wdata2   = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        @(posedge clk);
        #1;
        preload(12'h123, 16'h4A5B);
        preload(12'h050, 16'h1111);
        preload(12'h060, 16'h2222);
        preload(12'h200, 16'h3C3C);
        preload(12'h300, 16'hA000);
        preload(12'h301, 16'hA001);
        preload(12'h302, 16'hA002);
        preload(12'h7FF, 16'h0000);
        test_reset();
        test_idle_quiet();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_reset_in_issue();
        test_input_churn();
        n_checks++; if (sb_q.size() !== 0) begin n_errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL provide these requester ports, indexed 0=control FSM, 1=counter-increment unit, 2=DSKY I/O:
- req  in  3  access request per requester, level, held until ack.
- addr0/addr1/addr2  in  12 each  word address.
- wdata0/wdata1/wdata2  in  16 each  write data.
- we  in  3  write enable per requester, 1=write, 0=read.
- ack  out  3  one-hot, 1-cycle completion pulse.
- rdata  out  16  read data, valid while the matching ack is high.
- busy  out  1  high when not IDLE.
REQ-003 The block SHALL provide these memory-side ports:
- mem_addr  out  12  address to the single-port memory.
- mem_wdata  out  16  write data.
- mem_wr  out  1  write strobe.
- mem_rdata  in  16  read data, 1-cycle latency after mem_addr.

Function
REQ-004 The block SHALL implement the FSM IDLE -> ISSUE -> COMPLETE -> IDLE with 2-bit state encoding IDLE=0, ISSUE=1, COMPLETE=2.
REQ-005 In IDLE with any req bit high, the block SHALL latch the winner index, address, write data and write enable, and move to ISSUE.
REQ-006 In ISSUE, the block SHALL drive mem_addr and mem_wdata from the latched values, and pulse mem_wr for exactly 1 cycle if the latched access is a write.
REQ-007 In COMPLETE, the block SHALL assert ack for the winner only, set rdata equal to mem_rdata for reads (hold the previous rdata for writes), and return to IDLE.
REQ-008 Latency SHALL be 3 cycles from req sampled high in IDLE to ack high, and the block SHALL sustain at most 1 access per 3 cycles.
REQ-009 A requester SHALL NOT receive a second ack until it deasserts and reasserts req or the arbiter re-samples req in IDLE; a req held after its ack SHALL be treated as a new request.
REQ-010 Changes on req, addr, wdata or we after latching SHALL NOT affect the access in flight.
REQ-011 A requester that drops req while its access is in flight SHALL still have the access completed and acked.
REQ-012 mem_wr SHALL be 0 in every state except ISSUE with a latched write.
REQ-013 With req=0, the block SHALL stay in IDLE with all outputs quiescent.

Reset
REQ-014 rst high at a clock edge SHALL force state=IDLE, ack=0, mem_wr=0, busy=0, rdata=0, mem_addr=0, mem_wdata=0, and round-robin pointer=0.
REQ-015 rst asserted mid-access SHALL abort the access with no ack; a write aborted in ISSUE SHALL have mem_wr=0 from the reset edge onward.

Configuration
REQ-016 With MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at the index after the last winner, wraps 2->0, and the pointer updates only when a grant is made.
REQ-017 Without MEM_ARB_RR_EN, arbitration SHALL be fixed priority 0 > 1 > 2, and no pointer register SHALL exist.

Structure
REQ-018 A shared package SHALL hold the state encoding, requester index constants (REQ_CPU=0, REQ_CNT=1, REQ_IO=2), ADDR_W=12 and DATA_W=16.
REQ-019 The arbitration logic SHALL be one combinational sub-module, mem_arb_pick, with inputs req[2:0] and ptr[1:0] and outputs winner index and valid.

Verification
REQ-020 The bench SHALL cover at least these directed scenarios:
- Single read: req=001, addr0=0x123; mem returns 0x4A5B -> mem_addr=0x123 in ISSUE, ack=001 on cycle 3, rdata=0x4A5B, mem_wr never high.
- Single write: req=100, we=100, addr2=0x7FF, wdata2=0xBEEF -> one mem_wr pulse with mem_addr=0x7FF and mem_wdata=0xBEEF, then ack=100.
- Simultaneous req=111 held, fixed priority -> ack order 0,0,0,... and requester 1 never acked while req0 stays high.
- Simultaneous req=111 held, MEM_ARB_RR_EN -> ack order 0,1,2,0, one ack every 3 cycles.
- Reset in ISSUE during a write to 0x010 -> mem_wr=0 from the reset edge, no ack, busy=0, the next request is served normally.
- Input churn: change addr1 from 0x050 to 0x060 during ISSUE -> mem_addr stays 0x050, and ack is returned to requester 1 only.
